// File: rtl/fir_coeff_loader_if.sv
// Write / commit / readback bus between a coefficient host and fir_coeff_loader.
interface fir_coeff_loader_if;
   logic        i_wr_valid;
   logic        o_wr_ready;
   logic [3:0]  iu4_wr_addr;
   logic [31:0] is32_wr_data;
   logic        i_commit;
   logic        o_busy;
   logic        o_commit_done;
   logic        o_addr_err;
   logic [8:0]  ou9_dirty;
   logic [3:0]  iu4_rd_addr;
   logic [31:0] os32_rd_data;

   modport master (
      output i_wr_valid, iu4_wr_addr, is32_wr_data, i_commit, iu4_rd_addr,
      input  o_wr_ready, o_busy, o_commit_done, o_addr_err, ou9_dirty, os32_rd_data
   );

   modport slave (
      input  i_wr_valid, iu4_wr_addr, is32_wr_data, i_commit, iu4_rd_addr,
      output o_wr_ready, o_busy, o_commit_done, o_addr_err, ou9_dirty, os32_rd_data
   );
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered 9-tap FIR coefficient loader: writes land in a shadow bank,
// and a commit copies the whole shadow bank into the active bank on the next
// filter sample strobe, so the filter never sees a half-updated set.
module fir_coeff_loader #(
   parameter int RESET_PASSTHROUGH = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               ce,
   fir_coeff_loader_if.slave  bus,
   output logic [31:0]        os32_coeff_0,
   output logic [31:0]        os32_coeff_1,
   output logic [31:0]        os32_coeff_2,
   output logic [31:0]        os32_coeff_3,
   output logic [31:0]        os32_coeff_4,
   output logic [31:0]        os32_coeff_5,
   output logic [31:0]        os32_coeff_6,
   output logic [31:0]        os32_coeff_7,
   output logic [31:0]        os32_coeff_8
);

   localparam int          NTAPS      = 9;
   localparam logic [0:0]  ST_IDLE    = 1'b0;
   localparam logic [0:0]  ST_PENDING = 1'b1;
   // Tap 0 resets to ~1.0 in Q1.31 so the filter passes data through untouched.
   localparam logic [31:0] RST_C0     = (RESET_PASSTHROUGH != 0) ? 32'h7FFF_FFFF : 32'h0;

   logic [0:0]  state_q, state_d;
   logic [31:0] shadow_q [NTAPS];
   logic [31:0] shadow_d [NTAPS];
   logic [31:0] active_q [NTAPS];
   logic [31:0] active_d [NTAPS];
   logic [8:0]  dirty_q, dirty_d;
   logic        done_q, done_d;
   logic        addr_err_q, addr_err_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        wr_acc;

   // Writes are only taken in IDLE; a pending commit freezes the shadow bank.
   assign wr_acc = bus.i_wr_valid && (state_q == ST_IDLE);

   // Next-state: shadow writes, commit arming, and the ce-aligned bank copy.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      dirty_d    = dirty_q;
      done_d     = 1'b0;
      addr_err_d = 1'b0;
      rd_data_d  = '0;
      for (int i = 0; i < NTAPS; i++) begin
         if (bus.iu4_rd_addr == 4'(i)) rd_data_d = shadow_q[i];
      end
      case (state_q)
         ST_IDLE: begin
            if (wr_acc) begin
               if (bus.iu4_wr_addr > 4'd8) begin
                  addr_err_d = 1'b1;
               end else begin
                  for (int i = 0; i < NTAPS; i++) begin
                     if (bus.iu4_wr_addr == 4'(i)) begin
                        shadow_d[i] = bus.is32_wr_data;
                        dirty_d[i]  = 1'b1;
                     end
                  end
               end
            end
            // ce on this same edge is deliberately ignored: the copy waits for the next strobe.
            if (bus.i_commit) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (ce) begin
               active_d = shadow_q;
               dirty_d  = '0;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and bank registers; reset abandons any pending commit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         dirty_q    <= '0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
         rd_data_q  <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            shadow_q[i] <= (i == 0) ? RST_C0 : 32'h0;
            active_q[i] <= (i == 0) ? RST_C0 : 32'h0;
         end
      end else begin
         state_q    <= state_d;
         dirty_q    <= dirty_d;
         done_q     <= done_d;
         addr_err_q <= addr_err_d;
         rd_data_q  <= rd_data_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
      end
   end

   assign bus.o_wr_ready    = (state_q == ST_IDLE);
   assign bus.o_busy        = (state_q == ST_PENDING);
   assign bus.o_commit_done = done_q;
   assign bus.o_addr_err    = addr_err_q;
   assign bus.ou9_dirty     = dirty_q;
   assign bus.os32_rd_data  = rd_data_q;

   assign os32_coeff_0 = active_q[0];
   assign os32_coeff_1 = active_q[1];
   assign os32_coeff_2 = active_q[2];
   assign os32_coeff_3 = active_q[3];
   assign os32_coeff_4 = active_q[4];
   assign os32_coeff_5 = active_q[5];
   assign os32_coeff_6 = active_q[6];
   assign os32_coeff_7 = active_q[7];
   assign os32_coeff_8 = active_q[8];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: constant vector table, hand
// sequences for the commit corner cases, and random traffic against a
// transaction-level model of the two banks.
module tb_fir_coeff_loader;
   logic clk = 1'b0;
   logic rstn;
   logic ce;
   logic [8:0][31:0] cf;
   int n_chk = 0;
   int n_err = 0;

   fir_coeff_loader_if ifc ();

   fir_coeff_loader #(.RESET_PASSTHROUGH(1)) dut (
      .clk(clk), .rstn(rstn), .ce(ce), .bus(ifc.slave),
      .os32_coeff_0(cf[0]), .os32_coeff_1(cf[1]), .os32_coeff_2(cf[2]),
      .os32_coeff_3(cf[3]), .os32_coeff_4(cf[4]), .os32_coeff_5(cf[5]),
      .os32_coeff_6(cf[6]), .os32_coeff_7(cf[7]), .os32_coeff_8(cf[8])
   );

   always #5 clk = ~clk;

   // Reference model: the two banks as plain arrays plus a "commit armed" flag.
   logic [31:0] m_shadow [9];
   logic [31:0] m_active [9];
   logic [8:0]  m_dirty;
   bit          m_pend, m_done, m_err;
   logic [31:0] m_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         m_shadow[i] = (i == 0) ? 32'h7FFF_FFFF : 32'h0;
         m_active[i] = m_shadow[i];
      end
      m_dirty = '0; m_pend = 0; m_done = 0; m_err = 0; m_rd = '0;
   endtask

   task automatic check_model();
      chk("m_ready", 32'(ifc.o_wr_ready), 32'(!m_pend));
      chk("m_busy", 32'(ifc.o_busy), 32'(m_pend));
      chk("m_done", 32'(ifc.o_commit_done), 32'(m_done));
      chk("m_err", 32'(ifc.o_addr_err), 32'(m_err));
      chk("m_dirty", 32'(ifc.ou9_dirty), 32'(m_dirty));
      chk("m_rd", ifc.os32_rd_data, m_rd);
      for (int i = 0; i < 9; i++) chk($sformatf("m_coeff%0d", i), cf[i], m_active[i]);
   endtask

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic step(input bit wv, input logic [3:0] wa, input logic [31:0] wd,
                       input bit cm, input bit cev, input logic [3:0] ra);
      bit acc;
      int a, r;
      ifc.i_wr_valid = wv; ifc.iu4_wr_addr = wa; ifc.is32_wr_data = wd;
      ifc.i_commit = cm; ce = cev; ifc.iu4_rd_addr = ra;
      @(posedge clk);
      a = int'(wa); r = int'(ra);
      acc    = !m_pend && wv;
      m_err  = acc && (a > 8);
      m_done = m_pend && cev;
      m_rd   = (r < 9) ? m_shadow[r] : 32'h0;
      if (m_pend) begin
         if (cev) begin
            for (int i = 0; i < 9; i++) m_active[i] = m_shadow[i];
            m_dirty = '0;
            m_pend  = 0;
         end
      end else begin
         if (acc && a < 9) begin
            m_shadow[a] = wd;
            m_dirty[a]  = 1'b1;
         end
         if (cm) m_pend = 1;
      end
      #1;
      check_model();
   endtask

   typedef struct {
      bit wv; logic [3:0] wa; logic [31:0] wd; bit cm; bit ce; logic [3:0] ra;
      bit e_rdy; bit e_busy; bit e_done; bit e_err;
      logic [8:0] e_dirty; logic [31:0] e_rd; logic [31:0] e_c3;
   } vec_t;

   vec_t tbl [8];
   int   ndone;

   initial begin
      tbl[0] = '{1, 4'd3,  32'h1000_0000, 0, 0, 4'd3,  1, 0, 0, 0, 9'h008, 32'h0,         32'h0};
      tbl[1] = '{0, 4'd0,  32'h0,         1, 1, 4'd3,  0, 1, 0, 0, 9'h008, 32'h1000_0000, 32'h0};
      tbl[2] = '{0, 4'd0,  32'h0,         0, 0, 4'd0,  0, 1, 0, 0, 9'h008, 32'h7FFF_FFFF, 32'h0};
      tbl[3] = '{0, 4'd0,  32'h0,         0, 1, 4'd3,  1, 0, 1, 0, 9'h000, 32'h1000_0000, 32'h1000_0000};
      tbl[4] = '{0, 4'd0,  32'h0,         0, 0, 4'd3,  1, 0, 0, 0, 9'h000, 32'h1000_0000, 32'h1000_0000};
      tbl[5] = '{1, 4'd12, 32'hDEAD_BEEF, 0, 0, 4'd12, 1, 0, 0, 1, 9'h000, 32'h0,         32'h1000_0000};
      tbl[6] = '{0, 4'd0,  32'h0,         0, 0, 4'd12, 1, 0, 0, 0, 9'h000, 32'h0,         32'h1000_0000};
      tbl[7] = '{0, 4'd0,  32'h0,         0, 0, 4'd3,  1, 0, 0, 0, 9'h000, 32'h1000_0000, 32'h1000_0000};

      rstn = 1'b0; ce = 1'b0;
      ifc.i_wr_valid = 0; ifc.iu4_wr_addr = '0; ifc.is32_wr_data = '0;
      ifc.i_commit = 0; ifc.iu4_rd_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_coeff0", cf[0], 32'h7FFF_FFFF);
      for (int i = 1; i < 9; i++) chk($sformatf("rst_coeff%0d", i), cf[i], 32'h0);
      chk("rst_ready", 32'(ifc.o_wr_ready), 32'd1);
      chk("rst_busy", 32'(ifc.o_busy), 32'd0);
      chk("rst_dirty", 32'(ifc.ou9_dirty), 32'd0);
      rstn = 1'b1;

      // Constant vector table (includes commit+ce on same edge waiting for next ce).
      for (int k = 0; k < 8; k++) begin
         step(tbl[k].wv, tbl[k].wa, tbl[k].wd, tbl[k].cm, tbl[k].ce, tbl[k].ra);
         chk($sformatf("t%0d_ready", k), 32'(ifc.o_wr_ready), 32'(tbl[k].e_rdy));
         chk($sformatf("t%0d_busy", k), 32'(ifc.o_busy), 32'(tbl[k].e_busy));
         chk($sformatf("t%0d_done", k), 32'(ifc.o_commit_done), 32'(tbl[k].e_done));
         chk($sformatf("t%0d_err", k), 32'(ifc.o_addr_err), 32'(tbl[k].e_err));
         chk($sformatf("t%0d_dirty", k), 32'(ifc.ou9_dirty), 32'(tbl[k].e_dirty));
         chk($sformatf("t%0d_rd", k), ifc.os32_rd_data, tbl[k].e_rd);
         chk($sformatf("t%0d_c3", k), cf[3], tbl[k].e_c3);
      end

      // Commit held off by ce for 20 cycles.
      step(1, 4'd3, 32'h2000_0000, 0, 0, 4'd0);
      step(0, 4'd0, 32'h0, 1, 0, 4'd0);
      for (int k = 0; k < 20; k++) begin
         step(0, 4'd0, 32'h0, 0, 0, 4'd0);
         chk("hold_c3", cf[3], 32'h1000_0000);
         chk("hold_busy", 32'(ifc.o_busy), 32'd1);
         chk("hold_dirty", 32'(ifc.ou9_dirty), 32'h008);
      end
      step(0, 4'd0, 32'h0, 0, 1, 4'd0);
      chk("commit_c3", cf[3], 32'h2000_0000);
      chk("commit_dirty", 32'(ifc.ou9_dirty), 32'd0);
      chk("commit_done", 32'(ifc.o_commit_done), 32'd1);
      step(0, 4'd0, 32'h0, 0, 0, 4'd0);
      chk("commit_done_off", 32'(ifc.o_commit_done), 32'd0);

      // Write and commit on the same edge.
      step(1, 4'd8, 32'h8123_4567, 1, 0, 4'd0);
      step(0, 4'd0, 32'h0, 0, 1, 4'd0);
      chk("samedge_c8", cf[8], 32'h8123_4567);

      // Held write and repeat commit during PENDING.
      ndone = 0;
      step(0, 4'd0, 32'h0, 1, 0, 4'd0);
      ndone += int'(ifc.o_commit_done);
      step(1, 4'd2, 32'h0BAD_F00D, 1, 0, 4'd2);
      ndone += int'(ifc.o_commit_done);
      chk("pend_ready", 32'(ifc.o_wr_ready), 32'd0);
      chk("pend_dirty", 32'(ifc.ou9_dirty), 32'd0);
      step(1, 4'd2, 32'h0BAD_F00D, 0, 1, 4'd2);
      ndone += int'(ifc.o_commit_done);
      step(1, 4'd2, 32'h0BAD_F00D, 0, 0, 4'd2);
      ndone += int'(ifc.o_commit_done);
      chk("held_wr_dirty", 32'(ifc.ou9_dirty), 32'h004);
      for (int k = 0; k < 4; k++) begin
         step(0, 4'd2, 32'h0, 0, 1, 4'd2);
         ndone += int'(ifc.o_commit_done);
      end
      chk("held_wr_rd", ifc.os32_rd_data, 32'h0BAD_F00D);
      chk("single_done", 32'(ndone), 32'd1);

      // Reset mid-PENDING.
      step(1, 4'd5, 32'h5555_AAAA, 0, 0, 4'd0);
      step(0, 4'd0, 32'h0, 1, 0, 4'd0);
      step(0, 4'd0, 32'h0, 0, 0, 4'd0);
      ce = 1'b1;
      #2 rstn = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_busy", 32'(ifc.o_busy), 32'd0);
      chk("mid_rst_ready", 32'(ifc.o_wr_ready), 32'd1);
      chk("mid_rst_c0", cf[0], 32'h7FFF_FFFF);
      chk("mid_rst_c5", cf[5], 32'h0);
      chk("mid_rst_c3", cf[3], 32'h0);
      check_model();
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("mid_rst_nodone", 32'(ifc.o_commit_done), 32'd0);
      end
      rstn = 1'b1;
      step(0, 4'd5, 32'h0, 0, 1, 4'd5);
      chk("post_rst_nodone", 32'(ifc.o_commit_done), 32'd0);
      chk("post_rst_rd5", ifc.os32_rd_data, 32'h0);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 99) < 60),
              4'($urandom_range(0, 15)),
              $urandom,
              ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 99) < 30),
              4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter RESET_PASSTHROUGH, default 1; meaning: 1 = coefficient 0 resets to 32'h7FFF_FFFF with all others 0, 0 = all coefficients reset to 0.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ce  input  1  filter sample strobe, same signal that drives the filter's ce.
REQ-005 SHALL have port i_wr_valid  input  1  coefficient write request.
REQ-006 SHALL have port o_wr_ready  output  1  write may be accepted this cycle.
REQ-007 SHALL have port iu4_wr_addr  input  4  coefficient index for the write.
REQ-008 SHALL have port is32_wr_data  input  32  signed Q1.31 coefficient value.
REQ-009 SHALL have port i_commit  input  1  request to transfer the shadow bank to the active outputs.
REQ-010 SHALL have port o_busy  output  1  a commit is pending.
REQ-011 SHALL have port o_commit_done  output  1  one-cycle pulse after the active bank has been updated.
REQ-012 SHALL have port o_addr_err  output  1  one-cycle pulse on an accepted write with an address above 8.
REQ-013 SHALL have port ou9_dirty  output  9  per-tap flag: shadow bank differs from active bank because of a write since the last commit.
REQ-014 SHALL have port iu4_rd_addr  input  4  shadow readback index.
REQ-015 SHALL have port os32_rd_data  output  32  registered shadow readback data.
REQ-016 SHALL have ports os32_coeff_0 .. os32_coeff_8  output  32 each  active coefficients driving the filter.

Function
REQ-017 SHALL hold a 9x32 shadow bank and a 9x32 active bank; os32_coeff_n SHALL be driven directly from active[n] registers, with no combinational path from inputs.
REQ-018 SHALL implement the states IDLE and PENDING; o_wr_ready=1 and o_busy=0 in IDLE; o_wr_ready=0 and o_busy=1 in PENDING.
REQ-019 SHALL accept a write on a rising edge where i_wr_valid and o_wr_ready are both 1; an address of 0..8 SHALL update shadow[addr] and set ou9_dirty[addr] on that edge.
REQ-020 SHALL accept and discard a write to address 9..15, leaving the shadow bank and ou9_dirty unchanged and pulsing o_addr_err in the following cycle.
REQ-021 SHALL move from IDLE to PENDING on an edge where i_commit=1; a write accepted on the same edge SHALL be included in the commit.
REQ-022 SHALL, while in PENDING, stay in PENDING until an edge where ce=1; on that edge all nine active registers SHALL load from shadow simultaneously, ou9_dirty SHALL clear, and the state SHALL return to IDLE.
REQ-023 SHALL pulse o_commit_done for exactly one cycle, in the cycle after the active-bank update.
REQ-024 SHALL ignore i_commit while in PENDING; a second commit is neither queued nor counted.
REQ-025 SHALL ignore i_wr_valid while in PENDING; the write is not accepted, and the requester keeps valid asserted until o_wr_ready is 1.
REQ-026 SHALL, if ce=1 on the same edge that i_commit is first seen in IDLE, wait for the next ce; the active update never happens on the same edge as the commit request.
REQ-027 SHALL present os32_rd_data = shadow[iu4_rd_addr] one cycle after the address is applied, and 0 for addresses 9..15.
REQ-028 SHALL never modify the active bank at any time other than the REQ-022 edge, so that the filter never sees a partially updated coefficient set.

Reset
REQ-029 SHALL, while rstn=0 (asynchronously), set the state to IDLE and drive o_busy=0, o_wr_ready=1 (the IDLE value), o_commit_done=0, o_addr_err=0, ou9_dirty=0, os32_rd_data=0.
REQ-030 SHALL, while rstn=0, load the shadow and active banks with the same RESET_PASSTHROUGH pattern.
REQ-031 SHALL abandon a pending commit when reset is asserted during PENDING: no o_commit_done pulse, and the active bank takes its reset value.

Verification
REQ-032 SHALL be verified with: after reset, RESET_PASSTHROUGH=1 -> os32_coeff_0=32'h7FFFFFFF and the other eight = 0; o_wr_ready=1.
REQ-033 SHALL be verified with: write addr 3 = 32'h1000_0000 and commit with ce held low for 20 cycles -> os32_coeff_3 unchanged, o_busy=1 and ou9_dirty=9'h008 throughout; raise ce for one cycle -> os32_coeff_3=32'h1000_0000, ou9_dirty=0, o_commit_done high one cycle later.
REQ-034 SHALL be verified with: write to addr 12 -> o_addr_err pulses once, ou9_dirty=0, readback of addr 12 = 0.
REQ-035 SHALL be verified with: write to addr 8 and i_commit on the same edge, then ce -> os32_coeff_8 equals the written data.
REQ-036 SHALL be verified with: during PENDING, i_wr_valid held high and i_commit pulsed -> o_wr_ready=0; after the commit completes, the write is accepted once and a single o_commit_done is seen.
REQ-037 SHALL be verified with: rstn pulled low mid-PENDING -> outputs immediately at their reset values and no o_commit_done.
